// File: rtl/fpmul_arb.sv
// Shares one fixed-latency 3-operand fpmul between two requesters: one holding register per
// requester, round-robin issue, and a tag pipe that routes each result back to its owner.
module fpmul_arb #(
    parameter int unsigned LAT = 9,
    parameter int unsigned CW  = 4,
    localparam int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_pushin,
    input  logic [DW-1:0] p0_a,
    input  logic [DW-1:0] p0_b,
    input  logic [DW-1:0] p0_c,
    output logic          p0_full,
    output logic          p0_pushout,
    output logic [DW-1:0] p0_r,
    input  logic          p1_pushin,
    input  logic [DW-1:0] p1_a,
    input  logic [DW-1:0] p1_b,
    input  logic [DW-1:0] p1_c,
    output logic          p1_full,
    output logic          p1_pushout,
    output logic [DW-1:0] p1_r,
    output logic          mul_pushin,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    output logic [DW-1:0] mul_c,
    input  logic          mul_pushout,
    input  logic [DW-1:0] mul_r,
    output logic [CW-1:0] p0_inflight,
    output logic [CW-1:0] p1_inflight,
    output logic          busy,
    output logic          err
);

    logic          hold0_v, hold1_v, hold0_v_n, hold1_v_n;
    logic [DW-1:0] h0_a, h0_b, h0_c, h0_a_n, h0_b_n, h0_c_n;
    logic [DW-1:0] h1_a, h1_b, h1_c, h1_a_n, h1_b_n, h1_c_n;
    logic          rr, rr_n;
    logic          mul_own, mul_own_n;
    logic [LAT-1:0] tag_v, tag_v_n, tag_o, tag_o_n;
    logic          mul_pushin_n, p0_pushout_n, p1_pushout_n, busy_n, err_n;
    logic [DW-1:0] mul_a_n, mul_b_n, mul_c_n, p0_r_n, p1_r_n;
    logic [CW-1:0] p0_inflight_n, p1_inflight_n;
    logic          issue_c, win_c, ret_c, own_c;

    assign p0_full = hold0_v;
    assign p1_full = hold1_v;

    // Next-state: arbitration, capture, tag shift and result routing.
    always_comb begin
        hold0_v_n     = hold0_v;
        hold1_v_n     = hold1_v;
        h0_a_n        = h0_a;
        h0_b_n        = h0_b;
        h0_c_n        = h0_c;
        h1_a_n        = h1_a;
        h1_b_n        = h1_b;
        h1_c_n        = h1_c;
        rr_n          = rr;
        mul_own_n     = mul_own;
        mul_pushin_n  = 1'b0;
        mul_a_n       = mul_a;
        mul_b_n       = mul_b;
        mul_c_n       = mul_c;
        p0_pushout_n  = 1'b0;
        p1_pushout_n  = 1'b0;
        p0_r_n        = p0_r;
        p1_r_n        = p1_r;

        // On a tie the requester that did not win last time goes first.
        issue_c = hold0_v | hold1_v;
        win_c   = (hold0_v & hold1_v) ? ~rr : hold1_v;
        ret_c   = mul_pushout & tag_v[LAT-1];
        own_c   = tag_o[LAT-1];

        tag_v_n = {tag_v[LAT-2:0], mul_pushin};
        tag_o_n = {tag_o[LAT-2:0], mul_own};

        if (issue_c) begin
            mul_pushin_n = 1'b1;
            mul_own_n    = win_c;
            rr_n         = win_c;
            if (win_c) begin
                mul_a_n   = h1_a;
                mul_b_n   = h1_b;
                mul_c_n   = h1_c;
                hold1_v_n = 1'b0;
            end else begin
                mul_a_n   = h0_a;
                mul_b_n   = h0_b;
                mul_c_n   = h0_c;
                hold0_v_n = 1'b0;
            end
        end

        if (p0_pushin && !hold0_v) begin
            hold0_v_n = 1'b1;
            h0_a_n    = p0_a;
            h0_b_n    = p0_b;
            h0_c_n    = p0_c;
        end
        if (p1_pushin && !hold1_v) begin
            hold1_v_n = 1'b1;
            h1_a_n    = p1_a;
            h1_b_n    = p1_b;
            h1_c_n    = p1_c;
        end

        if (ret_c) begin
            if (own_c) begin
                p1_pushout_n = 1'b1;
                p1_r_n       = mul_r;
            end else begin
                p0_pushout_n = 1'b1;
                p0_r_n       = mul_r;
            end
        end

        p0_inflight_n = p0_inflight + CW'(issue_c & ~win_c) - CW'(ret_c & ~own_c);
        p1_inflight_n = p1_inflight + CW'(issue_c & win_c) - CW'(ret_c & own_c);

        // A result with no matching tag (or a tag with no result) is a protocol error.
        err_n  = err | (p0_pushin & hold0_v) | (p1_pushin & hold1_v)
               | (mul_pushout ^ tag_v[LAT-1]);
        busy_n = hold0_v_n | hold1_v_n | mul_pushin_n | (|tag_v_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold0_v     <= 1'b0;
            hold1_v     <= 1'b0;
            h0_a        <= '0;
            h0_b        <= '0;
            h0_c        <= '0;
            h1_a        <= '0;
            h1_b        <= '0;
            h1_c        <= '0;
            rr          <= 1'b1;
            mul_own     <= 1'b0;
            tag_v       <= '0;
            tag_o       <= '0;
            mul_pushin  <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_c       <= '0;
            p0_pushout  <= 1'b0;
            p1_pushout  <= 1'b0;
            p0_r        <= '0;
            p1_r        <= '0;
            p0_inflight <= '0;
            p1_inflight <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            hold0_v     <= hold0_v_n;
            hold1_v     <= hold1_v_n;
            h0_a        <= h0_a_n;
            h0_b        <= h0_b_n;
            h0_c        <= h0_c_n;
            h1_a        <= h1_a_n;
            h1_b        <= h1_b_n;
            h1_c        <= h1_c_n;
            rr          <= rr_n;
            mul_own     <= mul_own_n;
            tag_v       <= tag_v_n;
            tag_o       <= tag_o_n;
            mul_pushin  <= mul_pushin_n;
            mul_a       <= mul_a_n;
            mul_b       <= mul_b_n;
            mul_c       <= mul_c_n;
            p0_pushout  <= p0_pushout_n;
            p1_pushout  <= p1_pushout_n;
            p0_r        <= p0_r_n;
            p1_r        <= p1_r_n;
            p0_inflight <= p0_inflight_n;
            p1_inflight <= p1_inflight_n;
            busy        <= busy_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_fpmul_arb.sv
// Self-checking bench for fpmul_arb with a behavioural fixed-latency fpmul and per-requester
// result scoreboards.
module tb_fpmul_arb;

    localparam int unsigned LAT = 9;
    localparam int unsigned CW  = 4;
    localparam logic [63:0] B0 = 64'h4008000000000000;  // 3.0
    localparam logic [63:0] B1 = 64'h3FD0000000000000;  // 0.25
    localparam logic [63:0] C1 = 64'h3FF0000000000000;  // 1.0
    localparam logic [63:0] C2 = 64'h4000000000000000;  // 2.0

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p0_pushin = 1'b0, p1_pushin = 1'b0;
    logic [63:0] p0_a = '0, p0_b = '0, p0_c = '0, p1_a = '0, p1_b = '0, p1_c = '0;
    logic p0_full, p0_pushout, p1_full, p1_pushout;
    logic [63:0] p0_r, p1_r;
    logic mul_pushin, mul_pushout;
    logic [63:0] mul_a, mul_b, mul_c, mul_r;
    logic [CW-1:0] p0_inflight, p1_inflight;
    logic busy, err;

    int checks = 0;
    int errors = 0;
    int k0 = 0, k1 = 0, r0 = 0, r1 = 0;
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    logic orphan = 1'b0;
    logic alt_en = 1'b0, alt_have = 1'b0, alt_last = 1'b0;

    logic        mv [1:LAT];
    logic [63:0] mr [1:LAT];

    always #5 clk = ~clk;

    fpmul_arb #(.LAT(LAT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .p0_pushin(p0_pushin), .p0_a(p0_a), .p0_b(p0_b), .p0_c(p0_c),
        .p0_full(p0_full), .p0_pushout(p0_pushout), .p0_r(p0_r),
        .p1_pushin(p1_pushin), .p1_a(p1_a), .p1_b(p1_b), .p1_c(p1_c),
        .p1_full(p1_full), .p1_pushout(p1_pushout), .p1_r(p1_r),
        .mul_pushin(mul_pushin), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .mul_pushout(mul_pushout), .mul_r(mul_r),
        .p0_inflight(p0_inflight), .p1_inflight(p1_inflight),
        .busy(busy), .err(err)
    );

    function automatic logic [63:0] fmul3(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
        return $realtobits($bitstoreal(a) * $bitstoreal(b) * $bitstoreal(c));
    endfunction

    function automatic logic [63:0] op_a(input int k);
        return $realtobits(real'(k + 1));
    endfunction

    // Behavioural fpmul: fixed LAT, not affected by the arbiter reset.
    always @(posedge clk) begin
        mv[1] <= mul_pushin;
        mr[1] <= fmul3(mul_a, mul_b, mul_c);
        for (int i = 2; i <= LAT; i++) begin
            mv[i] <= mv[i-1];
            mr[i] <= mr[i-1];
        end
    end
    assign mul_pushout = mv[LAT] | orphan;
    assign mul_r       = mr[LAT];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every result must match the oldest outstanding push of its requester.
    always @(negedge clk) begin
        if (rst) begin
            if (p0_pushout) begin
                r0++;
                if (exp0.size() == 0) check("p0_unexpected", 64'd1, 64'd0);
                else check("p0_r", p0_r, exp0.pop_front());
            end
            if (p1_pushout) begin
                r1++;
                if (exp1.size() == 0) check("p1_unexpected", 64'd1, 64'd0);
                else check("p1_r", p1_r, exp1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && alt_en && mul_pushin) begin
            if (alt_have) check("alt_owner", 64'(mul_c == C2), 64'(!alt_last));
            alt_last = (mul_c == C2);
            alt_have = 1'b1;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_p0_full"}, 64'(p0_full), 64'd0);
        check({tag, "_p1_full"}, 64'(p1_full), 64'd0);
        check({tag, "_p0_pushout"}, 64'(p0_pushout), 64'd0);
        check({tag, "_p1_pushout"}, 64'(p1_pushout), 64'd0);
        check({tag, "_p0_r"}, p0_r, 64'd0);
        check({tag, "_p1_r"}, p1_r, 64'd0);
        check({tag, "_mul_pushin"}, 64'(mul_pushin), 64'd0);
        check({tag, "_mul_a"}, mul_a, 64'd0);
        check({tag, "_mul_b"}, mul_b, 64'd0);
        check({tag, "_mul_c"}, mul_c, 64'd0);
        check({tag, "_p0_inflight"}, 64'(p0_inflight), 64'd0);
        check({tag, "_p1_inflight"}, 64'(p1_inflight), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_zero(tag);
        exp0.delete();
        exp1.delete();
        repeat (LAT + 3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus: each enabled requester pushes if its hold is free.
    task automatic drive(input bit en0, input bit en1);
        if (en0 && !p0_full) begin
            p0_pushin = 1'b1; p0_a = op_a(k0); p0_b = B0; p0_c = C1;
            exp0.push_back(fmul3(p0_a, p0_b, p0_c));
            k0++;
        end
        if (en1 && !p1_full) begin
            p1_pushin = 1'b1; p1_a = op_a(k1); p1_b = B1; p1_c = C2;
            exp1.push_back(fmul3(p1_a, p1_b, p1_c));
            k1++;
        end
        @(posedge clk);
        #1;
        p0_pushin = 1'b0;
        p1_pushin = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp0.size() != 0 || exp1.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_bound", 64'(n < 300), 64'd1);
    endtask

    task automatic run_single(input string tag);
        int n = 0;
        p0_pushin = 1'b1; p0_a = 64'h4000000000000000; p0_b = B0; p0_c = C1;
        exp0.push_back(64'h4018000000000000);
        @(posedge clk);
        #1;
        p0_pushin = 1'b0;
        check({tag, "_full"}, 64'(p0_full), 64'd1);
        while (!p0_pushout && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check({tag, "_mul_pushin"}, 64'(mul_pushin), 64'd1);
                check({tag, "_mul_a"}, mul_a, 64'h4000000000000000);
                check({tag, "_inflight_up"}, 64'(p0_inflight), 64'd1);
                check({tag, "_busy"}, 64'(busy), 64'd1);
            end
        end
        check({tag, "_latency"}, 64'(n), 64'd11);
        check({tag, "_inflight_down"}, 64'(p0_inflight), 64'd0);
        check({tag, "_p1_pushout"}, 64'(p1_pushout), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_one_cycle"}, 64'(p0_pushout), 64'd0);
        wait_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, s0, s1, a0, a1, guard;
        logic [63:0] first_p1_a;

        do_reset("rst0");
        run_single("single");

        // Tie right after reset: requester 0 goes first.
        do_reset("rst1");
        drive(1'b1, 1'b1);
        check("tie_full0_e0", 64'(p0_full), 64'd1);
        check("tie_full1_e0", 64'(p1_full), 64'd1);
        @(posedge clk); #1;
        check("tie_full0_e1", 64'(p0_full), 64'd0);
        check("tie_full1_e1", 64'(p1_full), 64'd1);
        check("tie_first_owner", mul_c, C1);
        @(posedge clk); #1;
        check("tie_full1_e2", 64'(p1_full), 64'd0);
        check("tie_second_owner", mul_c, C2);
        n = 2;
        while (!p0_pushout && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("tie_p0_latency", 64'(n), 64'd11);
        @(posedge clk); #1;
        check("tie_p1_next", 64'(p1_pushout), 64'd1);
        check("tie_p0_gone", 64'(p0_pushout), 64'd0);
        wait_idle();

        // Sustained contention, 20 ops each.
        s0 = k0; s1 = k1; a0 = r0; a1 = r1; guard = 0;
        alt_have = 1'b0;
        alt_en   = 1'b1;
        while ((k0 < s0 + 20 || k1 < s1 + 20) && guard < 200) begin
            drive(k0 < s0 + 20, k1 < s1 + 20);
            guard++;
        end
        wait_idle();
        alt_en = 1'b0;
        check("cont_ret0", 64'(r0 - a0), 64'd20);
        check("cont_ret1", 64'(r1 - a1), 64'd20);
        check("cont_err", 64'(err), 64'd0);

        // Push while full: p0 wins the tie, p1 pushes again while still held.
        a1 = r1;
        first_p1_a = op_a(k1);
        drive(1'b1, 1'b1);
        p1_pushin = 1'b1; p1_a = 64'h4040000000000000; p1_b = B1; p1_c = C2;
        @(posedge clk); #1;
        p1_pushin = 1'b0;
        check("pwf_err", 64'(err), 64'd1);
        check("pwf_full1", 64'(p1_full), 64'd1);
        @(posedge clk); #1;
        check("pwf_held_a", mul_a, first_p1_a);
        wait_idle();
        check("pwf_ret1", 64'(r1 - a1), 64'd1);
        check("pwf_err_sticky", 64'(err), 64'd1);

        // Orphan result with an empty tag pipe.
        do_reset("rst2");
        orphan = 1'b1;
        @(posedge clk); #1;
        orphan = 1'b0;
        check("orphan_err", 64'(err), 64'd1);
        check("orphan_po0", 64'(p0_pushout), 64'd0);
        check("orphan_po1", 64'(p1_pushout), 64'd0);
        @(posedge clk); #1;
        check("orphan_po0_next", 64'(p0_pushout), 64'd0);
        check("orphan_po1_next", 64'(p1_pushout), 64'd0);

        // Reset with five operations in flight.
        do_reset("rst3");
        guard = 0;
        while (32'(p0_inflight) + 32'(p1_inflight) < 5 && guard < 50) begin
            drive(1'b1, 1'b1);
            guard++;
        end
        check("mid_inflight", 64'(32'(p0_inflight) + 32'(p1_inflight)), 64'd5);
        #2;
        do_reset("mid_rst");
        check("post_busy", 64'(busy), 64'd0);
        check("post_inflight0", 64'(p0_inflight), 64'd0);
        check("post_inflight1", 64'(p1_inflight), 64'd0);
        check("post_err", 64'(err), 64'd0);
        run_single("after_rst");
        check("after_rst_err", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
